// File: rtl/key_ui_defs_pkg.sv
// Shared definitions for the key-driven BCD editor: FSM state encodings,
// 7-segment patterns {dp,g,f,e,d,c,b,a} and digit wrap helpers.
package key_ui_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EDIT_TENS = 2'd1,
        ST_EDIT_ONES = 2'd2
    } state_e;

    localparam int SEG_DP_BIT = 7;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Digits live in 4 bits; wrap is a compare against the digit's max, no carry.
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] max);
        return (d == 4'd0) ? max : d - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high 7-segment pattern with decimal point; blank
// forces every segment, including dp, off.
module bcd_to_seg7
    import key_ui_defs_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    logic [7:0] pattern;

    always_comb begin
        pattern = SEG_BLANK;
        case (bcd_i)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        seg_o             = pattern;
        seg_o[SEG_DP_BIT] = dp_i;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/key_bcd_editor.sv
// Three-key editor for a two-digit BCD value: select steps tens -> ones -> commit,
// up/down wrap the selected digit, which blinks; idle edits time out without commit.
//
//  state        | meaning
//  ST_IDLE      | showing committed value, up/down ignored
//  ST_EDIT_TENS | up/down change working tens digit, tens blinks
//  ST_EDIT_ONES | up/down change working ones digit, ones blinks; select commits
module key_bcd_editor
    import key_ui_defs_pkg::*;
#(
    parameter int CLK_HZ    = 12_000_000,
    parameter int BLINK_HZ  = 2,
    parameter int TENS_MAX  = 9,
    parameter int ONES_MAX  = 9,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] key_pulse_i,
    output logic [7:0] value_bcd_o,
    output logic       commit_o,
    output logic       editing_o,
    output logic [7:0] seg_tens_o,
    output logic [7:0] seg_ones_o
);

    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_LOAD = (BLINK_HALF > 1) ? BLINK_HALF - 1 : 0;
    localparam int BLINK_W    = (BLINK_LOAD > 0) ? $clog2(BLINK_LOAD + 1) : 1;
    localparam int TMO_CYC    = TIMEOUT_S * CLK_HZ;
    localparam int TMO_LOAD   = (TMO_CYC > 1) ? TMO_CYC - 1 : 0;
    localparam int TMO_W      = (TMO_LOAD > 0) ? $clog2(TMO_LOAD + 1) : 1;
    localparam logic [3:0] T_MAX = 4'(TENS_MAX);
    localparam logic [3:0] O_MAX = 4'(ONES_MAX);

    state_e             state_q, state_d;
    logic [7:0]         committed_q, committed_d;
    logic [7:0]         working_q, working_d;
    logic               commit_q, commit_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic key_sel, key_up, key_dn;
    logic blink_restart, tmo_clear, timeout_hit;

    assign key_sel     = key_pulse_i[2];
    assign key_up      = key_pulse_i[0] & ~key_pulse_i[2];
    assign key_dn      = key_pulse_i[1] & ~key_pulse_i[0] & ~key_pulse_i[2];
    assign timeout_hit = (TIMEOUT_S != 0) && (tmo_cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            committed_q <= 8'h00;
            working_q   <= 8'h00;
            commit_q    <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            committed_q <= committed_d;
            working_q   <= working_d;
            commit_q    <= commit_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        committed_d   = committed_q;
        working_d     = working_q;
        commit_d      = 1'b0;
        blink_restart = 1'b0;
        tmo_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_sel) begin
                    state_d       = ST_EDIT_TENS;
                    working_d     = committed_q;
                    blink_restart = 1'b1;
                    tmo_clear     = 1'b1;
                end
            end
            ST_EDIT_TENS: begin
                tmo_clear     = key_sel | key_up | key_dn;
                blink_restart = tmo_clear;
                if (key_sel) begin
                    state_d = ST_EDIT_ONES;
                end else if (key_up) begin
                    working_d[7:4] = digit_inc(working_q[7:4], T_MAX);
                end else if (key_dn) begin
                    working_d[7:4] = digit_dec(working_q[7:4], T_MAX);
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EDIT_ONES: begin
                tmo_clear     = key_sel | key_up | key_dn;
                blink_restart = key_up | key_dn;
                if (key_sel) begin
                    state_d     = ST_IDLE;
                    committed_d = working_q;
                    commit_d    = 1'b1;
                end else if (key_up) begin
                    working_d[3:0] = digit_inc(working_q[3:0], O_MAX);
                end else if (key_dn) begin
                    working_d[3:0] = digit_dec(working_q[3:0], O_MAX);
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Blink and timeout counters only run while an edit state is held.
        if (state_d == ST_IDLE) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
            tmo_cnt_d   = '0;
        end else begin
            if (blink_restart) begin
                blink_cnt_d = BLINK_W'(BLINK_LOAD);
                blink_on_d  = 1'b1;
            end else if (blink_cnt_q == '0) begin
                blink_cnt_d = BLINK_W'(BLINK_LOAD);
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q - 1'b1;
                blink_on_d  = blink_on_q;
            end
            if (tmo_clear) begin
                tmo_cnt_d = TMO_W'(TMO_LOAD);
            end else if (tmo_cnt_q != '0) begin
                tmo_cnt_d = tmo_cnt_q - 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q;
            end
        end
    end

    logic [7:0] disp_val;
    logic       dp_tens, dp_ones, blank_tens, blank_ones;

    always_comb begin
        disp_val   = committed_q;
        dp_tens    = 1'b0;
        dp_ones    = 1'b0;
        blank_tens = 1'b0;
        blank_ones = 1'b0;
        case (state_q)
            ST_EDIT_TENS: begin
                disp_val   = working_q;
                dp_tens    = 1'b1;
                blank_tens = ~blink_on_q;
            end
            ST_EDIT_ONES: begin
                disp_val   = working_q;
                dp_ones    = 1'b1;
                blank_ones = ~blink_on_q;
            end
            default: ;
        endcase
    end

    bcd_to_seg7 u_seg_tens (
        .bcd_i   (disp_val[7:4]),
        .dp_i    (dp_tens),
        .blank_i (blank_tens),
        .seg_o   (seg_tens_o)
    );

    bcd_to_seg7 u_seg_ones (
        .bcd_i   (disp_val[3:0]),
        .dp_i    (dp_ones),
        .blank_i (blank_ones),
        .seg_o   (seg_ones_o)
    );

    assign value_bcd_o = committed_q;
    assign commit_o    = commit_q;
    assign editing_o   = (state_q != ST_IDLE);

endmodule
